posit_round_encode: RTL and testbench
=====================================

Name: posit_round_encode

Overview:
- Downstream neighbour of the mantissa-normalisation stage in the posit multiplier datapath.
- Consumes the normalised 64-bit mantissa, the 10-bit signed scale and the product sign.
- Packs regime, exponent and fraction into an N-bit posit, rounds round-to-nearest-even, saturates and two's-complements negative results.
- Multi-cycle start/done handshake with fixed latency.

Parameters:
N, 32, posit width in bits
ES, 3, exponent field width; scale = k*2^ES + e

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request; sampled only in IDLE
sign_in  in  1  product sign, 1 = negative
zero_in  in  1  product is zero, overrides mantissa/scale
nar_in  in  1  product is NaR, overrides all others
scale_in  in  10  two's-complement scale
mant_in  in  64  normalised mantissa; mant_in[63:62]==01, hidden bit at 62, fraction mant_in[61:0]
posit_out  out  N  encoded result; held until next completion
inexact  out  1  guard or sticky bit nonzero, or saturation applied
busy  out  1  high from start acceptance until return to IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous active-low.
- Reset values (rst_n low at a clk edge): state IDLE, posit_out 0, inexact 0, busy 0, done 0, internal registers 0.
  - Reset applied mid-operation aborts the operation; no done pulse is produced.
- States: IDLE -> PACK -> ROUND -> DONE -> IDLE.
  - IDLE: when start=1 at edge E0, latch all inputs; busy<=1; go to PACK. While busy, start is ignored.
  - PACK, edge E1:
    - k = scale>>>ES (arithmetic shift); e = scale[ES-1:0].
    - Regime: k>=0 gives (k+1) ones then a 0; k<0 gives (-k) zeros then a 1.
    - Build the bit string regime|e|mant[61:0].
    - Register the top N-1 bits as body, the next bit as guard, and the OR of the remaining bits as sticky.
    - Saturation flags: scale >= (N-2)*2^ES (240) forces sat_max; scale <= -(N-2)*2^ES-1 (-241) forces sat_min.
    - Go to ROUND.
  - ROUND, edge E2:
    - Round up (body+1) iff guard & (body[0] | sticky), and body != all ones.
    - sat_max gives body = all ones; sat_min gives body = 0...01.
    - Magnitude = {0, body}; if sign, posit_out <= two's complement of it, else the magnitude.
    - zero_in: posit_out <= 0, inexact 0. nar_in: posit_out <= 1 followed by zeros (0x80000000), inexact 0. nar_in wins over zero_in.
    - inexact <= guard | sticky | sat_max | sat_min.
    - done <= 1. Go to DONE.
  - DONE, edge E3: done<=0, busy<=0, return to IDLE.
    - start is sampled again at the next edge, giving 4 cycles per operation.
- Latency: posit_out is valid and done is high in the cycle after E2, i.e. two cycles after the start-sampling edge.
- Result is never rounded to zero (minpos floor) and never overflows into NaR (maxpos ceiling).
- mant_in not matching 01xx... is a caller error; no checking is done and the output is undefined but deterministic.
- All arithmetic is unsigned on body (N-1 bits); regime length is capped at N-1 by the saturation check.

Decomposition:
- Package posit_pkg:
  - N and ES defaults.
  - Constants POSIT_ZERO, POSIT_NAR, MAXPOS_BODY, MINPOS_BODY, SAT_HI_SCALE (240), SAT_LO_SCALE (-241).
  - FSM state encoding (IDLE, PACK, ROUND, DONE).
- One combinational sub-module, posit_regime_pack: takes k, e and fraction; returns body, guard and sticky. The same sub-module is reused by the adder datapath.

Test Plan:
- 1.0: scale 0, mant 0x4000000000000000, sign 0 -> posit_out 0x40000000, inexact 0, done exactly 2 cycles after start edge.
- Sign and exponent: sign 1, scale 0 -> 0xC0000000. Scale 1 -> 0x44000000. Scale 8 -> 0x60000000. Scale -1 -> 0x3C000000.
- RNE tie: scale 0, mant 0x4000000800000000 -> 0x40000000, inexact 1. Mant 0x4000001800000000 -> 0x40000002, inexact 1.
- Saturation: scale 300 -> 0x7FFFFFFF. Scale -300 -> 0x00000001. Scale -300 with sign 1 -> 0xFFFFFFFF. All with inexact 1.
- Specials: zero_in -> 0x00000000. nar_in -> 0x80000000. zero_in and nar_in together -> 0x80000000. All with inexact 0.
- Handshake: start held high continuously -> one result per 4 cycles, start during busy ignored. rst_n low in ROUND -> no done pulse, all outputs 0 next cycle.

Source files
------------

// File: rtl/posit_round_encode_pkg.sv
// Shared posit datapath definitions: default geometry, special encodings,
// saturation scale bounds and the round/encode FSM state type.
package posit_pkg;

    localparam int POSIT_N  = 32;
    localparam int POSIT_ES = 3;
    localparam int SCALE_W  = 10;
    localparam int MANT_W   = 64;
    localparam int FRAC_W   = 62;

    // Largest scale whose regime still fits in the N-1 bit body.
    function automatic int sat_hi_scale(input int n, input int es);
        return (n - 2) * (1 << es);
    endfunction

    localparam logic [POSIT_N-1:0] POSIT_ZERO  = '0;
    localparam logic [POSIT_N-1:0] POSIT_NAR   = {1'b1, {(POSIT_N-1){1'b0}}};
    localparam logic [POSIT_N-2:0] MAXPOS_BODY = '1;
    localparam logic [POSIT_N-2:0] MINPOS_BODY = {{(POSIT_N-2){1'b0}}, 1'b1};
    localparam int SAT_HI_SCALE = sat_hi_scale(POSIT_N, POSIT_ES);
    localparam int SAT_LO_SCALE = -SAT_HI_SCALE - 1;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        ROUND,
        DONE
    } state_e;

endpackage

// File: rtl/posit_regime_pack.sv
// Combinational regime/exponent/fraction packer shared by the posit multiplier
// and adder datapaths; yields the N-1 bit body plus guard and sticky.
module posit_regime_pack
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES,
    parameter int KW = SCALE_W - POSIT_ES
) (
    input  logic [KW-1:0]     k,
    input  logic [ES-1:0]     e,
    input  logic [FRAC_W-1:0] frac,
    output logic [N-2:0]      body,
    output logic              guard,
    output logic              sticky
);

    localparam int PAD = 1 << (KW - 1);
    localparam int WV  = 2 + ES + FRAC_W + PAD;

    logic [KW-2:0]        run_len;
    logic signed [WV-1:0] seed;
    logic signed [WV-1:0] packed_bits;

    // Seed "10" (k>=0) or "01" (k<0) and arithmetic-shift it right so the sign
    // fill extends the leading run to k+1 ones or -k zeros; the zero pad keeps
    // every tail bit inside the vector for the sticky OR.
    always_comb begin
        run_len     = k[KW-1] ? ~k[KW-2:0] : k[KW-2:0];
        seed        = {(k[KW-1] ? 2'b01 : 2'b10), e, frac, {PAD{1'b0}}};
        packed_bits = seed >>> run_len;
        body        = packed_bits[WV-1 -: N-1];
        guard       = packed_bits[WV-N];
        sticky      = |packed_bits[WV-N-1:0];
    end

endmodule

// File: rtl/posit_round_encode.sv
// Posit multiplier back end: packs scale/mantissa into an N-bit posit with
// round-to-nearest-even, minpos/maxpos saturation and sign application.
module posit_round_encode
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sign_in,
    input  logic                zero_in,
    input  logic                nar_in,
    input  logic [SCALE_W-1:0]  scale_in,
    input  logic [MANT_W-1:0]   mant_in,
    output logic [N-1:0]        posit_out,
    output logic                inexact,
    output logic                busy,
    output logic                done
);

    localparam int KW = SCALE_W - ES;
    localparam logic signed [SCALE_W-1:0] SAT_HI = SCALE_W'(sat_hi_scale(N, ES));
    localparam logic signed [SCALE_W-1:0] SAT_LO = SCALE_W'(-sat_hi_scale(N, ES) - 1);
    localparam logic [N-1:0] NAR_CODE = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-2:0] MINPOS   = {{(N-2){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic                sign_q, sign_d, zero_q, zero_d, nar_q, nar_d;
    logic [SCALE_W-1:0]  scale_q, scale_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;
    logic [N-2:0]        body_q, body_d;
    logic                guard_q, guard_d, sticky_q, sticky_d;
    logic                sat_max_q, sat_max_d, sat_min_q, sat_min_d;
    logic [N-1:0]        posit_q, posit_d;
    logic                inexact_q, inexact_d, busy_q, busy_d, done_q, done_d;

    logic [N-2:0]        pack_body, body_r;
    logic                pack_guard, pack_sticky, round_up;
    logic [N-1:0]        mag;

    // The leading "01" of a normalised mantissa is implied and never encoded.
    logic unused_mant_msbs;
    assign unused_mant_msbs = ^mant_in[MANT_W-1:FRAC_W];

    posit_regime_pack #(.N(N), .ES(ES), .KW(KW)) u_pack (
        .k      (scale_q[SCALE_W-1:ES]),
        .e      (scale_q[ES-1:0]),
        .frac   (frac_q),
        .body   (pack_body),
        .guard  (pack_guard),
        .sticky (pack_sticky)
    );

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        zero_d    = zero_q;
        nar_d     = nar_q;
        scale_d   = scale_q;
        frac_d    = frac_q;
        body_d    = body_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        sat_max_d = sat_max_q;
        sat_min_d = sat_min_q;
        posit_d   = posit_q;
        inexact_d = inexact_q;
        busy_d    = busy_q;
        done_d    = done_q;

        round_up = guard_q & (body_q[0] | sticky_q) & (body_q != '1);
        if (sat_max_q)      body_r = '1;
        else if (sat_min_q) body_r = MINPOS;
        else                body_r = body_q + {{(N-2){1'b0}}, round_up};
        mag = {1'b0, body_r};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = sign_in;
                    zero_d  = zero_in;
                    nar_d   = nar_in;
                    scale_d = scale_in;
                    frac_d  = mant_in[FRAC_W-1:0];
                    busy_d  = 1'b1;
                    state_d = PACK;
                end
            end
            PACK: begin
                body_d    = pack_body;
                guard_d   = pack_guard;
                sticky_d  = pack_sticky;
                sat_max_d = $signed(scale_q) >= SAT_HI;
                sat_min_d = $signed(scale_q) <= SAT_LO;
                state_d   = ROUND;
            end
            ROUND: begin
                if (nar_q) begin
                    posit_d   = NAR_CODE;
                    inexact_d = 1'b0;
                end else if (zero_q) begin
                    posit_d   = '0;
                    inexact_d = 1'b0;
                end else begin
                    posit_d   = sign_q ? -mag : mag;
                    inexact_d = guard_q | sticky_q | sat_max_q | sat_min_q;
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            nar_q     <= 1'b0;
            scale_q   <= '0;
            frac_q    <= '0;
            body_q    <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            sat_max_q <= 1'b0;
            sat_min_q <= 1'b0;
            posit_q   <= '0;
            inexact_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            zero_q    <= zero_d;
            nar_q     <= nar_d;
            scale_q   <= scale_d;
            frac_q    <= frac_d;
            body_q    <= body_d;
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
            sat_max_q <= sat_max_d;
            sat_min_q <= sat_min_d;
            posit_q   <= posit_d;
            inexact_q <= inexact_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign posit_out = posit_q;
    assign inexact   = inexact_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_posit_round_encode.sv
// Self-checking bench for posit_round_encode: directed vector table, handshake
// and reset corner sequences, and randomized ops against a bit-string model.
module tb_posit_round_encode;
    import posit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start, sign_in, zero_in, nar_in;
    logic [9:0]  scale_in;
    logic [63:0] mant_in;
    logic [31:0] posit_out;
    logic        inexact, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    posit_round_encode #(.N(32), .ES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sign_in   (sign_in),
        .zero_in   (zero_in),
        .nar_in    (nar_in),
        .scale_in  (scale_in),
        .mant_in   (mant_in),
        .posit_out (posit_out),
        .inexact   (inexact),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        string       name;
        logic        sign;
        logic        zero;
        logic        nar;
        int          scale;
        logic [63:0] mant;
        logic [31:0] exp_posit;
        logic        exp_inexact;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic s, input logic z, input logic n,
                                input int sc, input logic [63:0] m,
                                input logic [31:0] p, input logic x);
        vec_t v;
        v.name = nm; v.sign = s; v.zero = z; v.nar = n; v.scale = sc; v.mant = m;
        v.exp_posit = p; v.exp_inexact = x;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: write regime, exponent and fraction bits one by one into a
    // long string, then take body/guard/sticky and round by the RNE rule.
    function automatic logic [32:0] model(input logic s, input logic z, input logic n,
                                          input int scale, input logic [63:0] mant);
        logic [255:0] bits;
        int           pos, k, e;
        logic [30:0]  body;
        logic         g, st, x;
        logic [31:0]  mag;
        if (n) return {1'b0, POSIT_NAR};
        if (z) return {1'b0, POSIT_ZERO};
        if (scale >= SAT_HI_SCALE) begin
            mag = {1'b0, MAXPOS_BODY}; x = 1'b1;
        end else if (scale <= SAT_LO_SCALE) begin
            mag = {1'b0, MINPOS_BODY}; x = 1'b1;
        end else begin
            k = (scale >= 0) ? scale / 8 : -((-scale + 7) / 8);
            e = scale - k * 8;
            bits = '0;
            pos  = 255;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) begin bits[pos] = 1'b1; pos--; end
                bits[pos] = 1'b0; pos--;
            end else begin
                for (int i = 0; i < -k; i++) begin bits[pos] = 1'b0; pos--; end
                bits[pos] = 1'b1; pos--;
            end
            for (int i = 2; i >= 0; i--) begin bits[pos] = e[i]; pos--; end
            for (int i = 61; i >= 0; i--) begin bits[pos] = mant[i]; pos--; end
            body = bits[255:225];
            g    = bits[224];
            st   = |bits[223:0];
            if (g && (body[0] || st) && body != '1) body = body + 31'd1;
            mag = {1'b0, body};
            x   = g | st;
        end
        return {x, (s ? -mag : mag)};
    endfunction

    task automatic do_op(input logic s, input logic z, input logic n, input int sc,
                         input logic [63:0] m, output logic [31:0] p, output logic x,
                         output int lat);
        @(negedge clk);
        sign_in = s; zero_in = z; nar_in = n; scale_in = 10'(sc); mant_in = m;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        p = posit_out;
        x = inexact;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        logic        x;
        int          lat, n_done, first, prev, sc;
        logic        saw;
        logic [32:0] ref_v;
        logic        s, z, n;
        logic [63:0] m;

        rst_n = 1'b0; start = 1'b0; sign_in = 1'b0; zero_in = 1'b0; nar_in = 1'b0;
        scale_in = '0; mant_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_posit", posit_out, 0);
        check("reset_inexact", inexact, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst_n = 1'b1;

        vecs.push_back(mk("one",         0, 0, 0,    0, 64'h4000000000000000, 32'h40000000, 0));
        vecs.push_back(mk("neg_one",     1, 0, 0,    0, 64'h4000000000000000, 32'hC0000000, 0));
        vecs.push_back(mk("scale_1",     0, 0, 0,    1, 64'h4000000000000000, 32'h44000000, 0));
        vecs.push_back(mk("scale_8",     0, 0, 0,    8, 64'h4000000000000000, 32'h60000000, 0));
        vecs.push_back(mk("scale_m1",    0, 0, 0,   -1, 64'h4000000000000000, 32'h3C000000, 0));
        vecs.push_back(mk("tie_even",    0, 0, 0,    0, 64'h4000000800000000, 32'h40000000, 1));
        vecs.push_back(mk("tie_odd",     0, 0, 0,    0, 64'h4000001800000000, 32'h40000002, 1));
        vecs.push_back(mk("sat_hi",      0, 0, 0,  300, 64'h4000000000000000, 32'h7FFFFFFF, 1));
        vecs.push_back(mk("sat_hi_edge", 0, 0, 0,  240, 64'h4000000000000000, 32'h7FFFFFFF, 1));
        vecs.push_back(mk("below_sat",   0, 0, 0,  239, 64'h4000000000000000, 32'h7FFFFFFF, 1));
        vecs.push_back(mk("minpos_exact",0, 0, 0, -240, 64'h4000000000000000, 32'h00000001, 0));
        vecs.push_back(mk("sat_lo_edge", 0, 0, 0, -241, 64'h4000000000000000, 32'h00000001, 1));
        vecs.push_back(mk("sat_lo",      0, 0, 0, -300, 64'h4000000000000000, 32'h00000001, 1));
        vecs.push_back(mk("sat_lo_neg",  1, 0, 0, -300, 64'h4000000000000000, 32'hFFFFFFFF, 1));
        vecs.push_back(mk("zero",        0, 1, 0,   17, 64'h4123456789ABCDEF, 32'h00000000, 0));
        vecs.push_back(mk("nar",         1, 0, 1,  -50, 64'h4123456789ABCDEF, 32'h80000000, 0));
        vecs.push_back(mk("zero_nar",    0, 1, 1,    0, 64'h4000000000000000, 32'h80000000, 0));

        foreach (vecs[i]) begin
            do_op(vecs[i].sign, vecs[i].zero, vecs[i].nar, vecs[i].scale, vecs[i].mant, p, x, lat);
            check({vecs[i].name, "_latency"}, lat, 2);
            check({vecs[i].name, "_posit"}, p, vecs[i].exp_posit);
            check({vecs[i].name, "_inexact"}, x, vecs[i].exp_inexact);
            check({vecs[i].name, "_busy"}, busy, 1);
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, done, 0);
            check({vecs[i].name, "_hold"}, posit_out, vecs[i].exp_posit);
        end

        // start held high: one result per 4 cycles, inputs changed while busy
        @(negedge clk);
        sign_in = 1'b0; zero_in = 1'b0; nar_in = 1'b0; scale_in = '0;
        mant_in = 64'h4000000000000000;
        start = 1'b1;
        n_done = 0; first = -1; prev = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) sign_in = 1'b1;
            if (done) begin
                if (n_done == 0) begin
                    first = c;
                    check("hs_first_result", posit_out, 32'h40000000);
                end else if (n_done == 1) begin
                    check("hs_second_result", posit_out, 32'hC0000000);
                end
                if (prev >= 0) check("hs_period", c - prev, 4);
                prev = c;
                n_done++;
            end
        end
        start = 1'b0;
        check("hs_pulses", n_done, 4);
        check("hs_first_latency", first, 2);

        // reset while in ROUND aborts without a done pulse
        repeat (2) @(negedge clk);
        sign_in = 1'b0; scale_in = 10'd8;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_round_done", done, 0);
        check("rst_round_busy", busy, 0);
        check("rst_round_posit", posit_out, 0);
        check("rst_round_inexact", inexact, 0);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        check("rst_no_late_done", saw, 0);

        for (int i = 0; i < 200; i++) begin
            z = ($urandom_range(0, 15) == 0);
            n = ($urandom_range(0, 15) == 0);
            s = 1'($urandom);
            if ($urandom_range(0, 1) == 0) sc = int'($signed(10'($urandom)));
            else sc = int'($urandom_range(0, 500)) - 250;
            m = {$urandom, $urandom};
            m[63:62] = 2'b01;
            if ($urandom_range(0, 3) == 0) m[40:0] = '0;
            ref_v = model(s, z, n, sc, m);
            do_op(s, z, n, sc, m, p, x, lat);
            check("rand_latency", lat, 2);
            check("rand_posit", p, ref_v[31:0]);
            check("rand_inexact", x, ref_v[32]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
